// File: rtl/addsub_pipe.sv
// addsub_pipe: pipelined carry-lookahead adder/subtractor with NZCV flags.
//
// Computes {oCarry, oS} = iX + Ye + Cin, where Ye = iSub ? ~iY : iY and
// Cin = iUseCarry ? iCarry : iSub. oCarry is the raw carry out of the MSB, so
// a subtraction with no borrow gives oCarry=1.
//
// The WIDTH/BLOCK lookahead blocks are split across STAGES register stages,
// with the lowest blocks in stage 0. Each stage passes on the inter-block
// carry, the finished low sum bits (sharing one vector with the still-pending
// high X bits), and the pending high Ye bits. The last stage also registers
// the flags.
//
// Ports:
//   iClk, iRst            clock (rising edge), async active-high reset
//   iValid / oReady       input handshake (oReady = ~oValid | iReady)
//   iX, iY                operands
//   iSub                  1 = X - Y, 0 = X + Y
//   iUseCarry, iCarry     carry-in override (ADC/SBC)
//   oValid / iReady       output handshake
//   oS                    sum / difference
//   oCarry, oOverflow,
//   oZero, oNegative      registered flags for oS

module addsub_pipe #(
   parameter int WIDTH  = 32,
   parameter int BLOCK  = 8,
   parameter int STAGES = 2
) (
   input  logic             iClk,
   input  logic             iRst,
   input  logic             iValid,
   output logic             oReady,
   input  logic [WIDTH-1:0] iX,
   input  logic [WIDTH-1:0] iY,
   input  logic             iSub,
   input  logic             iUseCarry,
   input  logic             iCarry,
   output logic             oValid,
   input  logic             iReady,
   output logic [WIDTH-1:0] oS,
   output logic             oCarry,
   output logic             oOverflow,
   output logic             oZero,
   output logic             oNegative
);

   localparam int NB = WIDTH / BLOCK;

   logic             adv;
   logic [WIDTH-1:0] ye;
   logic             cin;

   assign ye  = iSub ? ~iY : iY;
   assign cin = iUseCarry ? iCarry : iSub;

   // All stages move together; a stalled output freezes the whole pipe.
   assign adv    = ~oValid | iReady;
   assign oReady = adv;

   for (genvar k = 0; k < STAGES; k++) begin : g_stg
      localparam int BLO = (k * NB) / STAGES;
      localparam int BHI = ((k + 1) * NB) / STAGES;
      localparam int LO  = BLO * BLOCK;
      localparam int HI  = BHI * BLOCK;

      // a_*: bits below LO are finished sum bits, bits from LO up are X.
      // b_in: Ye bits from LO up (index 0 corresponds to bit LO).
      logic [WIDTH-1:0]    a_in;
      logic [WIDTH-LO-1:0] b_in;
      logic                c_in;
      logic                v_in;
      logic [WIDTH-1:0]    a_d, a_q;
      logic                c_d, c_q;
      logic                v_q;

      if (k == 0) begin : g_head
         assign a_in = iX;
         assign b_in = ye;
         assign c_in = cin;
         assign v_in = iValid;
      end else begin : g_body
         assign a_in = g_stg[k-1].a_q;
         assign b_in = g_stg[k-1].g_fwd.b_q;
         assign c_in = g_stg[k-1].c_q;
         assign v_in = g_stg[k-1].v_q;
      end

      // Within a block every carry is a flat sum of products of g/p and the
      // block carry-in; only the block carry-out ripples to the next block.
      always_comb begin
         logic [BLOCK-1:0] g;
         logic [BLOCK-1:0] p;
         logic [BLOCK:0]   cc;
         logic             c;
         logic             t;
         g   = '0;
         p   = '0;
         cc  = '0;
         c   = c_in;
         t   = 1'b0;
         a_d = a_in;
         for (int bl = BLO; bl < BHI; bl++) begin
            for (int i = 0; i < BLOCK; i++) begin
               g[i] = a_in[bl*BLOCK+i] & b_in[bl*BLOCK+i-LO];
               p[i] = a_in[bl*BLOCK+i] ^ b_in[bl*BLOCK+i-LO];
            end
            for (int i = 0; i <= BLOCK; i++) begin
               t = c;
               for (int j = 0; j < i; j++) begin
                  t = t & p[j];
               end
               cc[i] = t;
               for (int j = 0; j < i; j++) begin
                  t = g[j];
                  for (int m = j + 1; m < i; m++) begin
                     t = t & p[m];
                  end
                  cc[i] = cc[i] | t;
               end
            end
            for (int i = 0; i < BLOCK; i++) begin
               a_d[bl*BLOCK+i] = p[i] ^ cc[i];
            end
            c = cc[BLOCK];
         end
         c_d = c;
      end

      always_ff @(posedge iClk or posedge iRst) begin
         if (iRst) begin
            a_q <= '0;
            c_q <= 1'b0;
            v_q <= 1'b0;
         end else if (adv) begin
            a_q <= a_d;
            c_q <= c_d;
            v_q <= v_in;
         end
      end

      if (k < STAGES - 1) begin : g_fwd
         logic [WIDTH-HI-1:0] b_d, b_q;

         assign b_d = b_in[WIDTH-LO-1:HI-LO];

         always_ff @(posedge iClk or posedge iRst) begin
            if (iRst) begin
               b_q <= '0;
            end else if (adv) begin
               b_q <= b_d;
            end
         end
      end else begin : g_last
         logic z_d, n_d, ov_d;
         logic z_q, n_q, ov_q;

         // Signed overflow: X and Ye agree in sign but the result does not.
         // a_in[WIDTH-1] is still X here because the top block is in this stage.
         assign z_d  = ~|a_d;
         assign n_d  = a_d[WIDTH-1];
         assign ov_d = (a_in[WIDTH-1] == b_in[WIDTH-LO-1]) &
                       (a_d[WIDTH-1] != a_in[WIDTH-1]);

         always_ff @(posedge iClk or posedge iRst) begin
            if (iRst) begin
               z_q  <= 1'b0;
               n_q  <= 1'b0;
               ov_q <= 1'b0;
            end else if (adv) begin
               z_q  <= z_d;
               n_q  <= n_d;
               ov_q <= ov_d;
            end
         end
      end
   end

   assign oValid    = g_stg[STAGES-1].v_q;
   assign oS        = g_stg[STAGES-1].a_q;
   assign oCarry    = g_stg[STAGES-1].c_q;
   assign oOverflow = g_stg[STAGES-1].g_last.ov_q;
   assign oZero     = g_stg[STAGES-1].g_last.z_q;
   assign oNegative = g_stg[STAGES-1].g_last.n_q;

endmodule

// File: tb/tb_addsub_pipe.sv
// Bench for addsub_pipe: directed flag/stall/reset cases on a (32,8,2)
// instance plus random streams with random backpressure on five parameter
// sets, checked against an arithmetic reference model.

module tb_addsub_pipe;

   localparam int NDUT = 5;
   localparam int PW[NDUT] = '{32, 32, 32, 64, 16};
   localparam int PB[NDUT] = '{8, 8, 8, 16, 4};
   localparam int PS[NDUT] = '{2, 1, 4, 2, 3};

   logic        clk;
   logic        rst;
   logic [63:0] x[NDUT];
   logic [63:0] y[NDUT];
   logic        vld[NDUT];
   logic        sub[NDUT];
   logic        uc[NDUT];
   logic        cy[NDUT];
   logic        rdy[NDUT];
   logic [63:0] s_o[NDUT];
   logic        ordy_o[NDUT];
   logic        v_o[NDUT];
   logic        c_o[NDUT];
   logic        ov_o[NDUT];
   logic        z_o[NDUT];
   logic        n_o[NDUT];

   int errors;
   int checks;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   for (genvar gi = 0; gi < NDUT; gi++) begin : g_dut
      localparam int W = PW[gi];
      logic [W-1:0] s_w;
      logic         ordy_w, v_w, c_w, ov_w, z_w, n_w;

      addsub_pipe #(.WIDTH(W), .BLOCK(PB[gi]), .STAGES(PS[gi])) u_dut (
         .iClk      (clk),
         .iRst      (rst),
         .iValid    (vld[gi]),
         .oReady    (ordy_w),
         .iX        (x[gi][W-1:0]),
         .iY        (y[gi][W-1:0]),
         .iSub      (sub[gi]),
         .iUseCarry (uc[gi]),
         .iCarry    (cy[gi]),
         .oValid    (v_w),
         .iReady    (rdy[gi]),
         .oS        (s_w),
         .oCarry    (c_w),
         .oOverflow (ov_w),
         .oZero     (z_w),
         .oNegative (n_w)
      );

      assign s_o[gi]    = 64'(s_w);
      assign ordy_o[gi] = ordy_w;
      assign v_o[gi]    = v_w;
      assign c_o[gi]    = c_w;
      assign ov_o[gi]   = ov_w;
      assign z_o[gi]    = z_w;
      assign n_o[gi]    = n_w;
   end

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
      end
   endtask

   function automatic logic [3:0] flg(input int d);
      return {n_o[d], z_o[d], c_o[d], ov_o[d]};
   endfunction

   // Reference: plain unsigned sum for S/C, true signed sum for V.
   task automatic model(input int d, input logic [63:0] xv, input logic [63:0] yv,
                        input logic sb, input logic u, input logic ci,
                        output logic [63:0] es, output logic [3:0] ef);
      int                 w;
      logic [64:0]        mask, xm, ym, tot;
      logic signed [66:0] xs, ys, ssum, lim;
      logic               cin, ov;
      w    = PW[d];
      mask = (65'd1 << w) - 65'd1;
      xm   = {1'b0, xv} & mask;
      ym   = (sb ? ~{1'b0, yv} : {1'b0, yv}) & mask;
      cin  = u ? ci : sb;
      tot  = xm + ym + {64'd0, cin};
      es   = tot[63:0] & mask[63:0];
      xs   = $signed({2'b00, xm});
      if (xm[w-1]) xs = xs - (67'sd1 <<< w);
      ys   = $signed({2'b00, ym});
      if (ym[w-1]) ys = ys - (67'sd1 <<< w);
      ssum = xs + ys + $signed({66'd0, cin});
      lim  = 67'sd1 <<< (w - 1);
      ov   = (ssum >= lim) || (ssum < -lim);
      ef   = {es[w-1], (es == 64'd0), tot[w], ov};
   endtask

   task automatic set_op(input int d, input logic [63:0] xv, input logic [63:0] yv,
                         input logic sb, input logic u, input logic ci);
      x[d] = xv; y[d] = yv; sub[d] = sb; uc[d] = u; cy[d] = ci;
   endtask

   // Single op on DUT 0 (STAGES=2): not valid after 1 cycle, valid after 2.
   task automatic dir_op(input string tag, input logic [63:0] xv, input logic [63:0] yv,
                         input logic sb, input logic u, input logic ci,
                         input logic [63:0] es, input logic [3:0] ef);
      @(negedge clk);
      set_op(0, xv, yv, sb, u, ci);
      vld[0] = 1'b1;
      rdy[0] = 1'b1;
      @(negedge clk);
      vld[0] = 1'b0;
      #1;
      chk({tag, "_lat1_valid"}, 64'(v_o[0]), 64'd0);
      @(negedge clk);
      #1;
      chk({tag, "_valid"}, 64'(v_o[0]), 64'd1);
      chk({tag, "_s"}, s_o[0], es);
      chk({tag, "_nzcv"}, 64'(flg(0)), 64'(ef));
   endtask

   task automatic run_random(input int d, input int nops);
      logic [63:0] q_s[$];
      logic [3:0]  q_f[$];
      logic [63:0] es, xr, yr, prev_s;
      logic [3:0]  ef, prev_f;
      logic        prev_stall;
      int          sent, got, cyc;
      sent = 0; got = 0; cyc = 0;
      prev_stall = 1'b0; prev_s = '0; prev_f = '0;
      while (got < nops && cyc < 4000) begin
         @(negedge clk);
         cyc++;
         rdy[d] = ($urandom_range(0, 2) != 0);
         if (sent < nops && $urandom_range(0, 3) != 0) begin
            xr = {$urandom, $urandom};
            yr = ($urandom_range(0, 4) == 0) ? xr : {$urandom, $urandom};
            set_op(d, xr, yr, 1'($urandom_range(0, 1)), ($urandom_range(0, 2) == 0),
                   1'($urandom_range(0, 1)));
            vld[d] = 1'b1;
         end else begin
            vld[d] = 1'b0;
         end
         #1;
         if (prev_stall) begin
            chk($sformatf("rnd%0d_stall_valid", d), 64'(v_o[d]), 64'd1);
            chk($sformatf("rnd%0d_stall_s", d), s_o[d], prev_s);
            chk($sformatf("rnd%0d_stall_f", d), 64'(flg(d)), 64'(prev_f));
         end
         chk($sformatf("rnd%0d_oready", d), 64'(ordy_o[d]), 64'(!v_o[d] || rdy[d]));
         if (v_o[d] && rdy[d]) begin
            chk($sformatf("rnd%0d_unexpected_result", d), 64'(q_s.size() > 0), 64'd1);
            if (q_s.size() > 0) begin
               es = q_s.pop_front();
               ef = q_f.pop_front();
               chk($sformatf("rnd%0d_s", d), s_o[d], es);
               chk($sformatf("rnd%0d_nzcv", d), 64'(flg(d)), 64'(ef));
            end
            got++;
         end
         if (vld[d] && ordy_o[d]) begin
            model(d, x[d], y[d], sub[d], uc[d], cy[d], es, ef);
            q_s.push_back(es);
            q_f.push_back(ef);
            sent++;
         end
         prev_stall = v_o[d] && !rdy[d];
         prev_s     = s_o[d];
         prev_f     = flg(d);
      end
      chk($sformatf("rnd%0d_results_received", d), 64'(got), 64'(nops));
      chk($sformatf("rnd%0d_queue_empty", d), 64'(q_s.size()), 64'd0);
      vld[d] = 1'b0;
      rdy[d] = 1'b1;
      repeat (PS[d] + 2) @(negedge clk);
      #1;
      chk($sformatf("rnd%0d_no_extra_result", d), 64'(v_o[d]), 64'd0);
   endtask

   initial begin
      errors = 0;
      checks = 0;
      rst    = 1'b1;
      for (int d = 0; d < NDUT; d++) begin
         set_op(d, '0, '0, 1'b0, 1'b0, 1'b0);
         vld[d] = 1'b0;
         rdy[d] = 1'b1;
      end

      // Reset state
      repeat (2) @(negedge clk);
      #1;
      for (int d = 0; d < NDUT; d++) begin
         chk($sformatf("rst%0d_valid", d), 64'(v_o[d]), 64'd0);
         chk($sformatf("rst%0d_s", d), s_o[d], 64'd0);
         chk($sformatf("rst%0d_nzcv", d), 64'(flg(d)), 64'd0);
         chk($sformatf("rst%0d_oready", d), 64'(ordy_o[d]), 64'd1);
      end
      @(negedge clk);
      rst = 1'b0;
      #1;
      chk("post_rst_oready", 64'(ordy_o[0]), 64'd1);

      // Directed arithmetic cases, flags as {N,Z,C,V}
      dir_op("add_ovf", 64'h7FFF_FFFF, 64'h1, 1'b0, 1'b0, 1'b0, 64'h8000_0000, 4'b1001);
      dir_op("sub_eq",  64'h5, 64'h5, 1'b1, 1'b0, 1'b0, 64'h0, 4'b0110);
      dir_op("sub_neg", 64'h3, 64'h5, 1'b1, 1'b0, 1'b0, 64'hFFFF_FFFE, 4'b1000);
      dir_op("adc",     64'hFFFF_FFFF, 64'h0, 1'b0, 1'b1, 1'b1, 64'h0, 4'b0110);
      dir_op("sbc",     64'h8000_0000, 64'h0, 1'b1, 1'b1, 1'b0, 64'h7FFF_FFFF, 4'b0011);

      // Stall: A reaches the output while B waits in stage 0; C must be refused
      @(negedge clk);
      set_op(0, 64'h10, 64'h20, 1'b0, 1'b0, 1'b0);
      vld[0] = 1'b1;
      rdy[0] = 1'b1;
      @(negedge clk);
      set_op(0, 64'h100, 64'h1, 1'b1, 1'b0, 1'b0);
      rdy[0] = 1'b0;
      #1;
      chk("stall_oready_before", 64'(ordy_o[0]), 64'd1);
      @(negedge clk);
      set_op(0, 64'hDEAD, 64'h1, 1'b0, 1'b0, 1'b0);
      #1;
      chk("stall_valid", 64'(v_o[0]), 64'd1);
      chk("stall_s", s_o[0], 64'h30);
      chk("stall_oready", 64'(ordy_o[0]), 64'd0);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         #1;
         chk($sformatf("stall_hold%0d_s", i), s_o[0], 64'h30);
         chk($sformatf("stall_hold%0d_valid", i), 64'(v_o[0]), 64'd1);
         chk($sformatf("stall_hold%0d_oready", i), 64'(ordy_o[0]), 64'd0);
      end
      vld[0] = 1'b0;
      rdy[0] = 1'b1;
      #1;
      chk("stall_release_oready", 64'(ordy_o[0]), 64'd1);
      @(negedge clk);
      #1;
      chk("stall_next_valid", 64'(v_o[0]), 64'd1);
      chk("stall_next_s", s_o[0], 64'hFF);
      @(negedge clk);
      #1;
      chk("stall_refused_op", 64'(v_o[0]), 64'd0);

      // Reset with two ops in flight
      @(negedge clk);
      set_op(0, 64'h1234_5678, 64'h1111_1111, 1'b0, 1'b0, 1'b0);
      vld[0] = 1'b1;
      rdy[0] = 1'b1;
      @(negedge clk);
      set_op(0, 64'hFFFF_FFFF, 64'h1, 1'b0, 1'b0, 1'b0);
      @(negedge clk);
      vld[0] = 1'b0;
      rdy[0] = 1'b0;
      #1;
      chk("inflight_valid", 64'(v_o[0]), 64'd1);
      chk("inflight_s", s_o[0], 64'h2345_6789);
      rst = 1'b1;
      #1;
      chk("async_rst_valid", 64'(v_o[0]), 64'd0);
      chk("async_rst_s", s_o[0], 64'd0);
      chk("async_rst_nzcv", 64'(flg(0)), 64'd0);
      chk("async_rst_oready", 64'(ordy_o[0]), 64'd1);
      @(negedge clk);
      rst    = 1'b0;
      rdy[0] = 1'b1;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         #1;
         chk($sformatf("after_rst%0d_valid", i), 64'(v_o[0]), 64'd0);
      end

      // Random streams with backpressure on every parameter set
      for (int d = 0; d < NDUT; d++) begin
         run_random(d, 100);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
